// File: rtl/display_pkg.sv
// Shared definitions for the display feeder: screen geometry defaults, the
// escape code, feeder FSM states and display status register bit positions.
package display_pkg;

    localparam int unsigned DEFAULT_CELLS_X = 80;
    localparam int unsigned DEFAULT_CELLS_Y = 30;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned DDR_W  = 16;
    localparam int unsigned DSR_W  = 16;
    localparam int unsigned ADDR_W = 12;

    localparam logic [BYTE_W-1:0] CHAR_ESC = 8'h1B;

    localparam int unsigned DSR_NOT_FULL_BIT = 15;
    localparam int unsigned DSR_OVERFLOW_BIT = 14;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ESC_ROW = 3'd1,
        ESC_COL = 3'd2,
        EMIT    = 3'd3,
        GAP     = 3'd4
    } feederState_t;

    // Limit an escape coordinate byte to the last valid cell index.
    function automatic int unsigned clampCoord(input logic [BYTE_W-1:0] value,
                                               input int unsigned limit);
        int unsigned v;
        v = 32'(value);
        return (v >= limit) ? (limit - 1) : v;
    endfunction

endpackage

// File: rtl/char_fifo.sv
// Synchronous FIFO with a registered occupancy count (one extra bit).
// Ports:
//   Clk, Reset        - clock, synchronous active-high reset
//   push, dataIn      - write request (ignored when full) and its data
//   pop, dataOut      - read request (ignored when empty); dataOut shows the head
//   full, empty       - occupancy flags from the registered count
//   fullNext          - full flag as it will be after the current edge
module char_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] dataIn,
    output logic [WIDTH-1:0] dataOut,
    output logic             full,
    output logic             empty,
    output logic             fullNext
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    countNext;
    logic             pushEn;
    logic             popEn;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign pushEn  = push && !full;
    assign popEn   = pop && !empty;
    assign dataOut = mem[rdPtr];

    // Occupancy after this edge.
    always_comb begin
        countNext = count;
        case ({pushEn, popEn})
            2'b10:   countNext = count + CW'(1);
            2'b01:   countNext = count - CW'(1);
            default: countNext = count;
        endcase
    end

    assign fullNext = (countNext == CW'(DEPTH));

    // Pointers and count.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (pushEn) wrPtr <= wrPtr + AW'(1);
            if (popEn)  rdPtr <= rdPtr + AW'(1);
            count <= countNext;
        end
    end

    // Storage; contents are don't-care until written.
    always_ff @(posedge Clk) begin
        if (pushEn) mem[wrPtr] <= dataIn;
    end

endmodule

// File: rtl/display_feeder.sv
// Buffers CPU writes to the display data register and hands them to the
// display driver one at a time under its Ready handshake. With
// DISPLAY_FEEDER_ESC_EN defined, ESC row col is turned into a cursor-address
// strobe; otherwise ESC is passed through like any other byte.
// Ports:
//   Clk, Reset            - clock, synchronous active-high reset
//   DdrWE, DdrIn          - CPU write strobe and data (low byte used)
//   DsrOut                - status: [15] not full, [14] sticky overflow
//   Ready                 - display driver can accept a strobe
//   CharWE, CharIn        - one-cycle character strobe and value
//   AddressWE, AddressIn  - one-cycle cursor-address strobe and cell address
module display_feeder
    import display_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned NUM_CELLS_X = DEFAULT_CELLS_X,
    parameter int unsigned NUM_CELLS_Y = DEFAULT_CELLS_Y
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              DdrWE,
    input  logic [DDR_W-1:0]  DdrIn,
    output logic [DSR_W-1:0]  DsrOut,
    input  logic              Ready,
    output logic              CharWE,
    output logic [BYTE_W-1:0] CharIn,
    output logic              AddressWE,
    output logic [ADDR_W-1:0] AddressIn
);

    logic [BYTE_W-1:0] fifoHead;
    logic              fifoFull;
    logic              fifoEmpty;
    logic              fifoFullNext;
    logic              fifoPop;

    feederState_t      state;
    feederState_t      stateNext;
    logic              charWeReg;
    logic              charWeNext;
    logic [BYTE_W-1:0] charInReg;
    logic [BYTE_W-1:0] charInNext;
    logic              overflow;
    logic              overflowNext;
    logic [DSR_W-1:0]  dsrReg;
    logic [DSR_W-1:0]  dsrNext;

    // Only the low byte of the data register reaches the display.
    logic [DDR_W-BYTE_W-1:0] unusedDdrHigh;
    assign unusedDdrHigh = DdrIn[DDR_W-1:BYTE_W];

    char_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (BYTE_W)
    ) uFifo (
        .Clk      (Clk),
        .Reset    (Reset),
        .push     (DdrWE),
        .pop      (fifoPop),
        .dataIn   (DdrIn[BYTE_W-1:0]),
        .dataOut  (fifoHead),
        .full     (fifoFull),
        .empty    (fifoEmpty),
        .fullNext (fifoFullNext)
    );

`ifdef DISPLAY_FEEDER_ESC_EN
    localparam int unsigned ROW_W = $clog2(NUM_CELLS_Y);
    localparam int unsigned COL_W = $clog2(NUM_CELLS_X);

    logic [ROW_W-1:0]  rowReg;
    logic [ROW_W-1:0]  rowNext;
    logic [COL_W-1:0]  colClamped;
    logic [ADDR_W-1:0] cellAddr;
    logic              addrWeReg;
    logic              addrWeNext;
    logic [ADDR_W-1:0] addrInReg;
    logic [ADDR_W-1:0] addrInNext;

    // Cell address of the stored row and the column byte at the FIFO head.
    assign colClamped = COL_W'(clampCoord(fifoHead, NUM_CELLS_X));
    assign cellAddr   = ADDR_W'(rowReg) * ADDR_W'(NUM_CELLS_X) + ADDR_W'(colClamped);
`endif

    // Next-state, FIFO pop and next output values.
    always_comb begin
        stateNext  = state;
        fifoPop    = 1'b0;
        charWeNext = 1'b0;
        charInNext = charInReg;
`ifdef DISPLAY_FEEDER_ESC_EN
        rowNext    = rowReg;
        addrWeNext = 1'b0;
        addrInNext = addrInReg;
`endif
        case (state)
            IDLE: begin
                if (!fifoEmpty && Ready) begin
                    fifoPop = 1'b1;
`ifdef DISPLAY_FEEDER_ESC_EN
                    if (fifoHead == CHAR_ESC) begin
                        stateNext = ESC_ROW;
                    end else begin
                        charWeNext = 1'b1;
                        charInNext = fifoHead;
                        stateNext  = EMIT;
                    end
`else
                    charWeNext = 1'b1;
                    charInNext = fifoHead;
                    stateNext  = EMIT;
`endif
                end
            end
`ifdef DISPLAY_FEEDER_ESC_EN
            // Row byte is only stored, so the driver need not be ready.
            ESC_ROW: begin
                if (!fifoEmpty) begin
                    fifoPop   = 1'b1;
                    rowNext   = ROW_W'(clampCoord(fifoHead, NUM_CELLS_Y));
                    stateNext = ESC_COL;
                end
            end
            ESC_COL: begin
                if (!fifoEmpty && Ready) begin
                    fifoPop    = 1'b1;
                    addrWeNext = 1'b1;
                    addrInNext = cellAddr;
                    stateNext  = EMIT;
                end
            end
`endif
            EMIT:    stateNext = GAP;
            // Quiet cycle lets the driver leave its post-write state.
            GAP:     stateNext = IDLE;
            default: stateNext = IDLE;
        endcase

        overflowNext = overflow | (DdrWE & fifoFull);
        dsrNext                   = '0;
        dsrNext[DSR_NOT_FULL_BIT] = ~fifoFullNext;
        dsrNext[DSR_OVERFLOW_BIT] = overflowNext;
    end

    // State and registered outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            charWeReg <= 1'b0;
            charInReg <= '0;
            overflow  <= 1'b0;
            dsrReg    <= DSR_W'(16'h8000);
        end else begin
            state     <= stateNext;
            charWeReg <= charWeNext;
            charInReg <= charInNext;
            overflow  <= overflowNext;
            dsrReg    <= dsrNext;
        end
    end

`ifdef DISPLAY_FEEDER_ESC_EN
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rowReg    <= '0;
            addrWeReg <= 1'b0;
            addrInReg <= '0;
        end else begin
            rowReg    <= rowNext;
            addrWeReg <= addrWeNext;
            addrInReg <= addrInNext;
        end
    end

    assign AddressWE = addrWeReg;
    assign AddressIn = addrInReg;
`else
    assign AddressWE = 1'b0;
    assign AddressIn = '0;
`endif

    assign CharWE = charWeReg;
    assign CharIn = charInReg;
    assign DsrOut = dsrReg;

endmodule
